// File: rtl/aap_pkg.sv
// Shared definitions for the AAP fetch front end: instruction word width,
// program-counter defaults, long-instruction flag position and fetch FSM states.
package aap_pkg;

  localparam int unsigned INSN_W       = 16;
  localparam int unsigned PC_W_DEF     = 24;
  localparam logic [23:0] RESET_PC_DEF = 24'h000000;

  // Bit of the first instruction word that marks a 32-bit (two-word) instruction.
  localparam int unsigned LONG_BIT     = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_long_word(input logic [INSN_W-1:0] w);
    return w[LONG_BIT];
  endfunction

endpackage

// File: rtl/aap_fetch_fifo.sv
// Instruction-word buffer for the fetch stage: synchronous FIFO with flush,
// single-word push and one- or two-word pop. Head and head+1 are exposed so a
// long instruction can be presented in a single cycle.
// Build option: AAP_FETCH_LONG_INSN_EN adds the two-word pop and head+1 output.
module aap_fetch_fifo
  import aap_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = INSN_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop1,
`ifdef AAP_FETCH_LONG_INSN_EN
  input  logic                     i_pop2,
  output logic [W-1:0]             o_next,
`endif
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [W-1:0]             o_head
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_pop_n;
  logic [AW:0]   w_push_n;

`ifdef AAP_FETCH_LONG_INSN_EN
  assign w_pop_n = i_pop2 ? CNT_W'(2) : (i_pop1 ? CNT_W'(1) : '0);
`else
  assign w_pop_n = i_pop1 ? CNT_W'(1) : '0;
`endif
  assign w_push_n = i_push ? CNT_W'(1) : '0;

  // Storage write; data is not reset, validity is tracked by the count alone.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy update; flush wins over same-cycle push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      // Depth is a power of two, so pointer overflow wraps modulo DEPTH.
      r_rd_ptr <= r_rd_ptr + w_pop_n[AW-1:0];
      r_count  <= r_count + w_push_n - w_pop_n;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
`ifdef AAP_FETCH_LONG_INSN_EN
  assign o_next  = r_mem[r_rd_ptr + AW'(1)];
`endif

endmodule

// File: rtl/aap_fetch_stage.sv
// AAP fetch stage: issues word-addressed instruction-memory requests, buffers
// returned words, assembles short/long instructions for the decoder with a
// valid/ready handshake, and handles branch redirect and halt.
// Build option: AAP_FETCH_LONG_INSN_EN enables 32-bit instruction assembly;
// without it every word is presented as a short instruction.
module aap_fetch_stage
  import aap_pkg::*;
#(
  parameter int unsigned     PC_W       = PC_W_DEF,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEF)
) (
  input  logic              speedy_clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  output logic [INSN_W-1:0] fetchoutput,
  output logic [INSN_W-1:0] fetchoutput_hi,
  output logic              fetch_valid,
  output logic              fetch_is_long,
  output logic [PC_W-1:0]   fetch_pc,
  input  logic              decode_ready
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CW + 1;
  localparam logic [CW:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  fetch_state_e      r_state;
  logic [PC_W-1:0]   r_fetch_pc;
  logic [PC_W-1:0]   r_head_pc;
  logic              r_inflight;
  logic              r_drop;

  logic [CW-1:0]     w_count;
  logic [INSN_W-1:0] w_head;
  logic [CW:0]       w_occupancy;
  logic              w_req;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [PC_W-1:0]   w_pop_words;
`ifdef AAP_FETCH_LONG_INSN_EN
  logic [INSN_W-1:0] w_next;
  logic              w_long;
`endif

  // Words buffered plus the one owed by memory must fit, so the FIFO never overflows.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_req       = (r_state == ST_RUN) && (w_occupancy < DEPTH_C);
  assign w_accept    = w_req && imem_ready && !redirect_valid;
  // A response is only kept if it matches an accepted request of the current stream.
  assign w_push      = imem_rvalid && r_inflight && !r_drop && !redirect_valid;

`ifdef AAP_FETCH_LONG_INSN_EN
  assign w_long         = is_long_word(w_head);
  assign w_valid        = w_long ? (w_count >= CW'(2)) : (w_count != '0);
  assign w_pop_words    = w_long ? PC_W'(2) : PC_W'(1);
  assign fetchoutput_hi = (w_valid && w_long) ? w_next : '0;
  assign fetch_is_long  = w_valid && w_long;
`else
  assign w_valid        = (w_count != '0);
  assign w_pop_words    = PC_W'(1);
  assign fetchoutput_hi = '0;
  assign fetch_is_long  = 1'b0;
`endif

  assign w_pop       = w_valid && decode_ready && !redirect_valid;

  assign fetchoutput = w_valid ? w_head : '0;
  assign fetch_valid = w_valid;
  assign fetch_pc    = r_head_pc;
  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;

  aap_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INSN_W)
  ) u_fifo (
    .i_clk   (speedy_clock),
    .i_rst_n (reset_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_wdata (imem_rdata),
    .i_pop1  (w_pop),
`ifdef AAP_FETCH_LONG_INSN_EN
    .i_pop2  (w_pop && w_long),
    .o_next  (w_next),
`endif
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Fetch control FSM: one idle cycle out of reset, then run/halt on halt_req.
  always_ff @(posedge speedy_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_RUN;
        ST_RUN:  if (halt_req)  r_state <= ST_HALT;
        ST_HALT: if (!halt_req) r_state <= ST_RUN;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Fetch/head program counters, in-flight tracking and stale-response discard.
  always_ff @(posedge speedy_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_head_pc  <= redirect_pc;
      r_inflight <= 1'b0;
      // Memory may still answer a request of the old stream: one accepted this
      // cycle (it saw the handshake even though we ignore it), or one whose data
      // has not arrived yet. That answer is marked for discard.
      r_drop     <= (w_req && imem_ready) || ((r_inflight || r_drop) && !imem_rvalid);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(1);
      end
      if (w_pop) begin
        r_head_pc <= r_head_pc + w_pop_words;
      end
      r_inflight <= w_accept;
      if (imem_rvalid) begin
        r_drop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aap_fetch_stage.sv
// Directed bench for aap_fetch_stage: memory responder answering exactly one
// cycle after each accepted request, a transfer monitor, and hand-computed
// expectations for latency, long assembly, back-pressure, redirect, halt,
// PC wrap and asynchronous reset.
module tb_aap_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [23:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [23:0] redirect_pc;
  logic        halt_req;
  logic [15:0] fetchoutput;
  logic [15:0] fetchoutput_hi;
  logic        fetch_valid;
  logic        fetch_is_long;
  logic [23:0] fetch_pc;
  logic        decode_ready;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [15:0] ovr [logic [23:0]];
  logic [56:0] xq [$];

  always #5 clk = ~clk;

  aap_fetch_stage #(
    .PC_W       (24),
    .FIFO_DEPTH (4),
    .RESET_PC   (24'h000000)
  ) dut (
    .speedy_clock   (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .fetchoutput    (fetchoutput),
    .fetchoutput_hi (fetchoutput_hi),
    .fetch_valid    (fetch_valid),
    .fetch_is_long  (fetch_is_long),
    .fetch_pc       (fetch_pc),
    .decode_ready   (decode_ready)
  );

  // Memory contents: address+1 in the low 15 bits (short words) unless overridden.
  function automatic logic [15:0] mem_word(input logic [23:0] a);
    if (ovr.exists(a)) return ovr[a];
    return {1'b0, a[14:0]} + 16'd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic dr);
    step();
    reset_n        = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    decode_ready   = dr;
    repeat (2) step();
    xq.delete();
    reset_n = 1'b1;
  endtask

  function automatic logic [56:0] xfer(input int unsigned i);
    if (i < xq.size()) return xq[i];
    return '1;
  endfunction

  // Memory responder: handshake seen before an edge returns data in the next cycle.
  initial begin : memory
    logic        mhs;
    logic [23:0] maddr;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      mhs   = imem_req && imem_ready;
      maddr = imem_addr;
      @(posedge clk);
      mhs = mhs && reset_n;
      #1;
      imem_rvalid = mhs;
      imem_rdata  = mhs ? mem_word(maddr) : '0;
    end
  end

  // Transfer monitor: records every instruction the decoder accepts.
  always @(negedge clk) begin
    if (reset_n && fetch_valid && decode_ready && !redirect_valid)
      xq.push_back({fetch_pc, fetch_is_long, fetchoutput, fetchoutput_hi});
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    reset_n        = 1'b0;
    imem_ready     = 1'b1;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    decode_ready   = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",    imem_req,       0);
    check("rst_addr",   imem_addr,      0);
    check("rst_valid",  fetch_valid,    0);
    check("rst_long",   fetch_is_long,  0);
    check("rst_out",    fetchoutput,    0);
    check("rst_hi",     fetchoutput_hi, 0);
    check("rst_pc",     fetch_pc,       0);

    // Two short words: first valid on cycle 3
    do_reset(1'b1);
    @(negedge clk);
    check("t1_idle_req",   imem_req,    0);
    check("t1_idle_valid", fetch_valid, 0);
    @(negedge clk);
    check("t1_c1_req",  imem_req,  1);
    check("t1_c1_addr", imem_addr, 0);
    @(negedge clk);
    check("t1_c2_addr",  imem_addr,   1);
    check("t1_c2_valid", fetch_valid, 0);
    @(negedge clk);
    check("t1_c3_valid", fetch_valid, 1);
    check("t1_c3_out",   fetchoutput, 16'h0001);
    check("t1_c3_pc",    fetch_pc,    0);
    @(negedge clk);
    check("t1_c4_out",  fetchoutput,   16'h0002);
    check("t1_c4_pc",   fetch_pc,      1);
    check("t1_c4_long", fetch_is_long, 0);

    // Long instruction 8123_4567 at address 0
    ovr[24'h000000] = 16'h8123;
    ovr[24'h000001] = 16'h4567;
    do_reset(1'b1);
    repeat (4) @(negedge clk);
`ifdef AAP_FETCH_LONG_INSN_EN
    check("t2_c3_valid", fetch_valid, 0);
    @(negedge clk);
    check("t2_valid", fetch_valid,    1);
    check("t2_long",  fetch_is_long,  1);
    check("t2_out",   fetchoutput,    16'h8123);
    check("t2_hi",    fetchoutput_hi, 16'h4567);
    check("t2_pc",    fetch_pc,       0);
    @(negedge clk);
    check("t2_next_pc",   fetch_pc,      2);
    check("t2_next_out",  fetchoutput,   16'h0003);
    check("t2_next_long", fetch_is_long, 0);
`else
    check("t2_valid", fetch_valid,    1);
    check("t2_long",  fetch_is_long,  0);
    check("t2_out",   fetchoutput,    16'h8123);
    check("t2_hi",    fetchoutput_hi, 0);
    check("t2_pc",    fetch_pc,       0);
    @(negedge clk);
    check("t2_next_pc",  fetch_pc,       1);
    check("t2_next_out", fetchoutput,    16'h4567);
    check("t2_next_hi",  fetchoutput_hi, 0);
`endif
    ovr.delete();

    // Back-pressure: requests stop at four buffered words, outputs hold
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    check("t3_c4_req", imem_req, 1);
    @(negedge clk);
    check("t3_c5_req", imem_req, 0);
    for (int c = 6; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("t3_c%0d_req", c),   imem_req,    0);
      check($sformatf("t3_c%0d_valid", c), fetch_valid, 1);
      check($sformatf("t3_c%0d_out", c),   fetchoutput, 16'h0001);
      check($sformatf("t3_c%0d_pc", c),    fetch_pc,    0);
    end
    step();
    decode_ready = 1'b1;
    repeat (6) step();
    for (int unsigned i = 0; i < 4; i++)
      check($sformatf("t3_drain%0d", i), xfer(i), {24'(i), 1'b0, 16'(i + 1), 16'h0000});

    // Redirect while a request is outstanding
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 24'h000100;
    @(negedge clk);
    check("t4_redir_req", imem_req, 1);
    step();
    redirect_valid = 1'b0;
    xq.delete();
    @(negedge clk);
    check("t4_r1_valid", fetch_valid, 0);
    check("t4_r1_addr",  imem_addr,   24'h000100);
    check("t4_r1_req",   imem_req,    1);
    @(negedge clk);
    check("t4_r2_valid", fetch_valid, 0);
    check("t4_r2_addr",  imem_addr,   24'h000101);
    repeat (4) step();
    check("t4_x0", xfer(0), {24'h000100, 1'b0, 16'h0101, 16'h0000});
    check("t4_x1", xfer(1), {24'h000101, 1'b0, 16'h0102, 16'h0000});

    // Halt mid-stream, drain, then resume sequentially
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    step();
    halt_req = 1'b1;
    @(negedge clk);
    check("t5_h0_req", imem_req, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t5_h%0d_req", c), imem_req, 0);
    end
    check("t5_drained", fetch_valid, 0);
    check("t5_count",   xq.size(),   6);
    check("t5_last",    xfer(5),     {24'h000005, 1'b0, 16'h0006, 16'h0000});
    step();
    halt_req = 1'b0;
    @(negedge clk);
    check("t5_still_halt_req", imem_req, 0);
    @(negedge clk);
    check("t5_resume_req",  imem_req,  1);
    check("t5_resume_addr", imem_addr, 24'h000006);
    repeat (4) step();
    check("t5_resume_x", xfer(6), {24'h000006, 1'b0, 16'h0007, 16'h0000});

    // PC wrap from 24'hFFFFFF
    ovr[24'hFFFFFF] = 16'h0ABC;
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 24'hFFFFFF;
    step();
    redirect_valid = 1'b0;
    xq.delete();
    @(negedge clk);
    check("t6_addr_top",  imem_addr, 24'hFFFFFF);
    @(negedge clk);
    check("t6_addr_wrap", imem_addr, 24'h000000);
    @(negedge clk);
    check("t6_top_pc",  fetch_pc,    24'hFFFFFF);
    check("t6_top_out", fetchoutput, 16'h0ABC);
    @(negedge clk);
    check("t6_wrap_pc",  fetch_pc,    24'h000000);
    check("t6_wrap_out", fetchoutput, 16'h0001);
    ovr.delete();

    // Asynchronous reset mid-stream
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    check("t7_pre_pc", fetch_pc, 2);
    step();
    reset_n = 1'b0;
    #1;
    check("t7_valid", fetch_valid,    0);
    check("t7_req",   imem_req,       0);
    check("t7_addr",  imem_addr,      0);
    check("t7_out",   fetchoutput,    0);
    check("t7_hi",    fetchoutput_hi, 0);
    check("t7_long",  fetch_is_long,  0);
    check("t7_pc",    fetch_pc,       0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_restart_valid", fetch_valid, 1);
    check("t7_restart_out",   fetchoutput, 16'h0001);
    check("t7_restart_pc",    fetch_pc,    0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
